// File: rtl/lieat_wbck_arb.sv
// Writeback arbiter for the long-instruction tracking table and the ALU short path.
// Optional ALU anti-starvation counter is enabled by defining LIEAT_WBARB_STARVE_EN.
module lieat_wbck_arb #(
    parameter  int LONGI_DEPTH = 4,
    parameter  int STARVE_MAX  = 3,
    parameter  int XLEN        = 32,
    parameter  int REG_IDX     = 5,
    localparam int ITAG_W      = $clog2(LONGI_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alu_wb_valid,
    output logic               alu_wb_ready,
    input  logic [XLEN-1:0]    alu_wb_pc,
    input  logic [XLEN-1:0]    alu_wb_data,
    input  logic               alu_wb_en,
    input  logic [REG_IDX-1:0] alu_wb_rd,
    input  logic               longi_disp_valid,
    output logic               longi_disp_ready,
    input  logic [REG_IDX-1:0] longi_disp_rd,
    input  logic [XLEN-1:0]    longi_disp_pc,
    input  logic               longi_disp_lsu,
    output logic [ITAG_W-1:0]  longi_disp_itag,
    input  logic               longi_wb_valid,
    output logic               longi_wb_ready,
    input  logic [ITAG_W-1:0]  longi_wb_itag,
    input  logic [XLEN-1:0]    longi_wb_data,
    input  logic [REG_IDX-1:0] dep_rs1,
    input  logic [REG_IDX-1:0] dep_rs2,
    output logic               dep_hazard,
    output logic               wb_valid,
    output logic               wb_en,
    output logic               wb_lsu,
    output logic [REG_IDX-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_pc,
    output logic [XLEN-1:0]    wb_data,
    output logic               longi_empty
);

    logic [LONGI_DEPTH-1:0] valid_q, valid_d;
    logic [LONGI_DEPTH-1:0] lsu_q;
    logic [REG_IDX-1:0]     rd_q [LONGI_DEPTH];
    logic [XLEN-1:0]        pc_q [LONGI_DEPTH];
    logic [ITAG_W-1:0]      alloc_ptr_q, alloc_ptr_d;

    logic               wb_valid_q, wb_valid_d;
    logic               wb_en_q, wb_en_d;
    logic               wb_lsu_q, wb_lsu_d;
    logic               wb_long_q, wb_long_d;
    logic [REG_IDX-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_pc_q, wb_pc_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;

    logic alu_force;
    logic disp_fire;
    logic long_grant;
    logic long_hit;
    logic alu_grant;

    assign longi_disp_ready = ~valid_q[alloc_ptr_q];
    assign longi_disp_itag  = alloc_ptr_q;
    assign disp_fire        = longi_disp_valid & longi_disp_ready;

    // The long path owns the port unless the ALU has been starved long enough.
    assign longi_wb_ready = ~(alu_force & alu_wb_valid);
    assign alu_wb_ready   = ~longi_wb_valid | alu_force;
    assign long_grant     = longi_wb_valid & longi_wb_ready;
    assign alu_grant      = alu_wb_valid & alu_wb_ready;
    assign long_hit       = long_grant & valid_q[longi_wb_itag];

`ifdef LIEAT_WBARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 2);
    logic [CNT_W-1:0] starve_q, starve_d;

    assign alu_force = (starve_q == CNT_W'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (alu_grant) begin
            starve_d = '0;
        end else if (alu_wb_valid & ~alu_wb_ready) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign alu_force = 1'b0;
`endif

    // A freed entry is cleared before the dispatch set, so a same-cycle
    // release only becomes allocatable once it shows up in valid_q.
    always_comb begin
        valid_d     = valid_q;
        alloc_ptr_d = alloc_ptr_q;
        if (long_hit) begin
            valid_d[longi_wb_itag] = 1'b0;
        end
        if (disp_fire) begin
            valid_d[alloc_ptr_q] = 1'b1;
            alloc_ptr_d          = alloc_ptr_q + ITAG_W'(1);
        end
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        wb_lsu_d   = 1'b0;
        wb_long_d  = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_pc_d    = wb_pc_q;
        wb_data_d  = wb_data_q;
        if (long_hit) begin
            wb_valid_d = 1'b1;
            wb_en_d    = (rd_q[longi_wb_itag] != '0);
            wb_lsu_d   = lsu_q[longi_wb_itag];
            wb_long_d  = 1'b1;
            wb_rd_d    = rd_q[longi_wb_itag];
            wb_pc_d    = pc_q[longi_wb_itag];
            wb_data_d  = longi_wb_data;
        end else if (alu_grant) begin
            wb_valid_d = 1'b1;
            wb_en_d    = alu_wb_en & (alu_wb_rd != '0);
            wb_rd_d    = alu_wb_rd;
            wb_pc_d    = alu_wb_pc;
            wb_data_d  = alu_wb_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            alloc_ptr_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_lsu_q    <= 1'b0;
            wb_long_q   <= 1'b0;
            wb_rd_q     <= '0;
            wb_pc_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            alloc_ptr_q <= alloc_ptr_d;
            wb_valid_q  <= wb_valid_d;
            wb_en_q     <= wb_en_d;
            wb_lsu_q    <= wb_lsu_d;
            wb_long_q   <= wb_long_d;
            wb_rd_q     <= wb_rd_d;
            wb_pc_q     <= wb_pc_d;
            wb_data_q   <= wb_data_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        if (disp_fire) begin
            rd_q[alloc_ptr_q]  <= longi_disp_rd;
            pc_q[alloc_ptr_q]  <= longi_disp_pc;
            lsu_q[alloc_ptr_q] <= longi_disp_lsu;
        end
    end

    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = wb_valid_q & wb_en_q & (wb_rd_q == dep_rs1);
        hit2 = wb_valid_q & wb_en_q & (wb_rd_q == dep_rs2);
        for (int i = 0; i < LONGI_DEPTH; i++) begin
            if (valid_q[i] && (rd_q[i] == dep_rs1)) hit1 = 1'b1;
            if (valid_q[i] && (rd_q[i] == dep_rs2)) hit2 = 1'b1;
        end
        dep_hazard = (hit1 & (dep_rs1 != '0)) | (hit2 & (dep_rs2 != '0));
    end

    assign longi_empty = ~(|valid_q) & ~wb_long_q;
    assign wb_valid    = wb_valid_q;
    assign wb_en       = wb_en_q;
    assign wb_lsu      = wb_lsu_q;
    assign wb_rd       = wb_rd_q;
    assign wb_pc       = wb_pc_q;
    assign wb_data     = wb_data_q;

endmodule
